// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud strobe generator, receive FIFO with host pop port,
// sticky error flags and level/error interrupt.
module uart_rx_ctrl #(
    parameter int DIV_W  = 16,
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter int THRESH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             flush,
    input  logic             clr_err,
    input  logic [7:0]       RBR,
    input  logic             setRBRF,
    input  logic             setOE,
    input  logic             setFE,
    input  logic             setPE,
    output logic             RxEn,
    output logic             RBRF,
    input  logic             rd_req,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic [AW:0]      level,
    output logic [2:0]       err,
    output logic             irq
);

    localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]      LVL_THR  = (AW+1)'(THRESH);
    localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push_pend;

    logic             push;
    logic             pop;
    logic             ovr;
    logic             wr_en;
    logic [AW:0]      level_next;
    logic [2:0]       err_next;

    // Baud generator: compare is >= so a lowered divisor wraps immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            RxEn <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            RxEn <= 1'b0;
        end else if (cnt >= div) begin
            cnt  <= '0;
            RxEn <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_ONE;
            RxEn <= 1'b0;
        end
    end

    always_comb begin
        pop        = rd_req && (level != '0) && !flush;
        push       = push_pend && !flush;
        ovr        = push && (level == LVL_FULL) && !pop;
        wr_en      = push && !ovr;
        level_next = level;
        if (flush)
            level_next = '0;
        else if (wr_en && !pop)
            level_next = level + LVL_ONE;
        else if (!wr_en && pop)
            level_next = level - LVL_ONE;
        err_next = (clr_err ? 3'b000 : err) | {setOE | ovr, setFE, setPE};
    end

    // Pending push counts toward fullness so the receiver cannot load a byte with no slot
    assign RBRF = ({1'b0, level} + {{(AW+1){1'b0}}, push_pend}) == {1'b0, LVL_FULL};

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr] <= RBR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_pend <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            err       <= 3'b000;
            irq       <= 1'b0;
        end else begin
            push_pend <= setRBRF && !flush;
            level     <= level_next;
            err       <= err_next;
            irq       <= (level_next >= LVL_THR) | (|err_next);
            rd_valid  <= pop;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_en)
                    wptr <= wptr + PTR_ONE;
                if (pop) begin
                    rptr    <= rptr + PTR_ONE;
                    rd_data <= mem[rptr];
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: expected popped bytes are queued at stimulus time
// and compared by an independent monitor on every rd_valid pulse.
module tb_uart_rx_ctrl;
    localparam int DIV_W  = 16;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;
    localparam int THRESH = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div;
    logic             flush;
    logic             clr_err;
    logic [7:0]       RBR;
    logic             setRBRF;
    logic             setOE;
    logic             setFE;
    logic             setPE;
    logic             RxEn;
    logic             RBRF;
    logic             rd_req;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [AW:0]      level;
    logic [2:0]       err;
    logic             irq;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    uart_rx_ctrl #(.DIV_W(DIV_W), .DEPTH(DEPTH), .AW(AW), .THRESH(THRESH)) dut (
        .clk(clk), .rst(rst), .en(en), .div(div), .flush(flush), .clr_err(clr_err),
        .RBR(RBR), .setRBRF(setRBRF), .setOE(setOE), .setFE(setFE), .setPE(setPE),
        .RxEn(RxEn), .RBRF(RBRF), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .level(level), .err(err), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        setRBRF = 1'b1;
        tick();
        setRBRF = 1'b0;
        RBR = b;
        tick();
    endtask

    task automatic pop_expect(input logic [7:0] b);
        exp_q.push_back(b);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected byte
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst === 1'b1 && rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", {24'h0, rd_data}, {24'h0, e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; en = 1'b0; div = '0; flush = 1'b0; clr_err = 1'b0; RBR = 8'h00;
        setRBRF = 1'b0; setOE = 1'b0; setFE = 1'b0; setPE = 1'b0; rd_req = 1'b0;
        tick(); tick();
        chk("reset_RxEn", {31'h0, RxEn}, 32'd0);
        chk("reset_level", {29'h0, level}, 32'd0);
        chk("reset_err", {29'h0, err}, 32'd0);
        chk("reset_irq", {31'h0, irq}, 32'd0);
        chk("reset_RBRF", {31'h0, RBRF}, 32'd0);
        chk("reset_rd_valid", {31'h0, rd_valid}, 32'd0);
        chk("reset_rd_data", {24'h0, rd_data}, 32'd0);
        rst = 1'b1;

        // Baud: div=3 -> one strobe every 4 clocks
        en = 1'b1; div = 16'd3;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rxen_div3", {31'h0, RxEn}, (i % 4 == 3) ? 32'd1 : 32'd0);
        end
        div = 16'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rxen_div0", {31'h0, RxEn}, 32'd1);
        end
        en = 1'b0;
        tick();
        chk("rxen_disabled", {31'h0, RxEn}, 32'd0);
        en = 1'b1; div = 16'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rxen_restart", {31'h0, RxEn}, (i == 3) ? 32'd1 : 32'd0);
        end
        en = 1'b0;
        tick();

        // Capture: RBR valid only after the setRBRF edge
        setRBRF = 1'b1; RBR = 8'h00;
        tick();
        setRBRF = 1'b0; RBR = 8'hA5;
        chk("cap_level_pending", {29'h0, level}, 32'd0);
        tick();
        chk("cap_level", {29'h0, level}, 32'd1);
        chk("cap_irq", {31'h0, irq}, 32'd1);
        tick();
        pop_expect(8'hA5);
        chk("cap_level_after_pop", {29'h0, level}, 32'd0);
        chk("cap_irq_after_pop", {31'h0, irq}, 32'd0);

        // Errors
        setFE = 1'b1;
        tick();
        setFE = 1'b0;
        chk("err_fe", {29'h0, err}, 32'd2);
        chk("err_fe_irq", {31'h0, irq}, 32'd1);
        clr_err = 1'b1; setPE = 1'b1;
        tick();
        setPE = 1'b0;
        chk("err_set_beats_clr", {29'h0, err}, 32'd1);
        tick();
        clr_err = 1'b0;
        chk("err_cleared", {29'h0, err}, 32'd0);
        chk("err_cleared_irq", {31'h0, irq}, 32'd0);

        // Full FIFO, simultaneous push/pop, defensive overrun
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        setRBRF = 1'b1;
        tick();
        setRBRF = 1'b0; RBR = 8'h04;
        chk("full_rbrf_pending", {31'h0, RBRF}, 32'd1);
        tick();
        chk("full_level", {29'h0, level}, 32'd4);
        chk("full_rbrf", {31'h0, RBRF}, 32'd1);
        setRBRF = 1'b1;
        tick();
        setRBRF = 1'b0; RBR = 8'h05;
        pop_expect(8'h01);
        chk("full_pushpop_level", {29'h0, level}, 32'd4);
        chk("full_pushpop_err", {29'h0, err}, 32'd0);
        push_byte(8'h66);
        chk("ovr_err", {29'h0, err}, 32'd4);
        chk("ovr_level", {29'h0, level}, 32'd4);
        exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        exp_q.push_back(8'h04); exp_q.push_back(8'h05);
        rd_req = 1'b1;
        repeat (4) tick();
        chk("drain_level", {29'h0, level}, 32'd0);
        tick();
        rd_req = 1'b0;
        chk("empty_pop_ignored", {31'h0, rd_valid}, 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovr_cleared", {29'h0, err}, 32'd0);

        // Flush overrides pop
        push_byte(8'h07); push_byte(8'h08); push_byte(8'h09);
        chk("flush_pre_level", {29'h0, level}, 32'd3);
        flush = 1'b1; rd_req = 1'b1;
        tick();
        flush = 1'b0; rd_req = 1'b0;
        chk("flush_level", {29'h0, level}, 32'd0);
        chk("flush_rd_valid", {31'h0, rd_valid}, 32'd0);

        // Asynchronous reset mid-operation
        push_byte(8'h11); push_byte(8'h22);
        setOE = 1'b1;
        tick();
        setOE = 1'b0;
        chk("pre_rst_err", {29'h0, err}, 32'd4);
        en = 1'b1; div = 16'd1;
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_RxEn", {31'h0, RxEn}, 32'd0);
        chk("arst_level", {29'h0, level}, 32'd0);
        chk("arst_err", {29'h0, err}, 32'd0);
        chk("arst_irq", {31'h0, irq}, 32'd0);
        chk("arst_RBRF", {31'h0, RBRF}, 32'd0);
        chk("arst_rd_data", {24'h0, rd_data}, 32'd0);
        en = 1'b0;
        tick();
        rst = 1'b1;
        tick(); tick();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
